// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter: shares the core DDR host port between the display frame
// player (requester 0, fixed priority) and the MPEG frame-store client
// (requester 1). Ownership is granted per transaction, as framed by each
// requester's acquire. A grant is never released while read beats are
// still returning. Requester 1 is guaranteed service after MAX_CONSEC back
// to back requester-0 grants.
//
// state  | meaning
// IDLE   | no owner, command strobes blocked, next owner chosen from acquire
// OWN0   | display owns the port, commands and responses routed to/from it
// OWN1   | MPEG client owns the port, commands and responses routed to/from it
module ddr_port_arbiter #(
  parameter int MAX_CONSEC = 4
) (
  input  logic             clkddr,
  input  logic             reset,
  input  logic [1:0]       m_acquire,
  input  logic [1:0]       m_read,
  input  logic [1:0]       m_write,
  input  logic [1:0][28:0] m_addr,
  input  logic [1:0][7:0]  m_burstcnt,
  input  logic [1:0][63:0] m_wdata,
  input  logic [1:0][7:0]  m_byteenable,
  output logic [1:0]       m_busy,
  output logic [1:0]       m_rdata_ready,
  output logic [63:0]      m_rdata,
  output logic             ddr_read,
  output logic             ddr_write,
  output logic [28:0]      ddr_addr,
  output logic [7:0]       ddr_burstcnt,
  output logic [63:0]      ddr_wdata,
  output logic [7:0]       ddr_byteenable,
  input  logic             ddr_busy,
  input  logic             ddr_rdata_ready,
  input  logic [63:0]      ddr_rdata,
  output logic [1:0]       grant
);

  // consec0 needs to reach MAX_CONSEC; never narrower than 3 bits
  localparam int CW = ($clog2(MAX_CONSEC + 1) > 3) ? $clog2(MAX_CONSEC + 1) : 3;
  localparam logic [CW-1:0] CMAX = CW'(MAX_CONSEC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [8:0]      r_outstd;
  logic [8:0]      w_outstd_nxt;
  logic [8:0]      w_inc;
  logic [8:0]      w_dec;
  logic [CW-1:0]   r_consec0;
  logic [CW-1:0]   w_consec0_nxt;
  logic            w_own;
  logic            w_sel;
  logic            w_acq_own;

  // last command driven to DDR, held on the bus while nobody owns it
  logic [28:0]     r_last_addr;
  logic [7:0]      r_last_burstcnt;
  logic [63:0]     r_last_wdata;
  logic [7:0]      r_last_byteenable;

  assign w_own     = (r_state != S_IDLE);
  assign w_sel     = (r_state == S_OWN1);
  assign w_acq_own = m_acquire[w_sel];
  assign m_rdata   = ddr_rdata;
  assign grant     = {r_state == S_OWN1, r_state == S_OWN0};

  // command mux toward DDR and busy/ready routing back to the owner only
  always_comb begin
    m_busy         = 2'b11;
    m_rdata_ready  = 2'b00;
    ddr_read       = 1'b0;
    ddr_write      = 1'b0;
    ddr_addr       = r_last_addr;
    ddr_burstcnt   = r_last_burstcnt;
    ddr_wdata      = r_last_wdata;
    ddr_byteenable = r_last_byteenable;
    if (w_own) begin
      ddr_read              = m_read[w_sel];
      ddr_write             = m_write[w_sel];
      ddr_addr              = m_addr[w_sel];
      ddr_burstcnt          = m_burstcnt[w_sel];
      ddr_wdata             = m_wdata[w_sel];
      ddr_byteenable        = m_byteenable[w_sel];
      m_busy[w_sel]         = ddr_busy;
      m_rdata_ready[w_sel]  = ddr_rdata_ready;
    end
  end

  // outstanding read beats; stray beats with nothing pending are dropped
  always_comb begin
    w_inc        = (w_own && ddr_read && !ddr_busy) ? {1'b0, ddr_burstcnt} : 9'd0;
    w_dec        = (ddr_rdata_ready && (r_outstd != 9'd0)) ? 9'd1 : 9'd0;
    w_outstd_nxt = r_outstd + w_inc - w_dec;
  end

  // owner selection, release and starvation bookkeeping
  always_comb begin
    w_state_nxt   = r_state;
    w_consec0_nxt = r_consec0;
    case (r_state)
      S_IDLE: begin
        if (!m_acquire[1]) begin
          w_consec0_nxt = '0;
        end
        if (m_acquire[1] && (!m_acquire[0] || (r_consec0 >= CMAX))) begin
          w_state_nxt   = S_OWN1;
          w_consec0_nxt = '0;
        end else if (m_acquire[0]) begin
          w_state_nxt = S_OWN0;
          if (m_acquire[1]) begin
            w_consec0_nxt = (r_consec0 >= CMAX) ? CMAX : r_consec0 + CW'(1);
          end
        end
      end
      S_OWN0, S_OWN1: begin
        if (!w_acq_own && (w_outstd_nxt == 9'd0)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // state, counters and the idle-hold copy of the command bus
  always_ff @(posedge clkddr) begin
    if (reset) begin
      r_state           <= S_IDLE;
      r_outstd          <= 9'd0;
      r_consec0         <= '0;
      r_last_addr       <= '0;
      r_last_burstcnt   <= '0;
      r_last_wdata      <= '0;
      r_last_byteenable <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_outstd  <= w_outstd_nxt;
      r_consec0 <= w_consec0_nxt;
      if (w_own) begin
        r_last_addr       <= ddr_addr;
        r_last_burstcnt   <= ddr_burstcnt;
        r_last_wdata      <= ddr_wdata;
        r_last_byteenable <= ddr_byteenable;
      end
    end
  end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb_ddr_port_arbiter: directed vectors with hand-computed expectations.
module tb_ddr_port_arbiter;

  logic             clkddr = 1'b0;
  logic             reset;
  logic [1:0]       m_acquire;
  logic [1:0]       m_read;
  logic [1:0]       m_write;
  logic [1:0][28:0] m_addr;
  logic [1:0][7:0]  m_burstcnt;
  logic [1:0][63:0] m_wdata;
  logic [1:0][7:0]  m_byteenable;
  logic [1:0]       m_busy;
  logic [1:0]       m_rdata_ready;
  logic [63:0]      m_rdata;
  logic             ddr_read;
  logic             ddr_write;
  logic [28:0]      ddr_addr;
  logic [7:0]       ddr_burstcnt;
  logic [63:0]      ddr_wdata;
  logic [7:0]       ddr_byteenable;
  logic             ddr_busy;
  logic             ddr_rdata_ready;
  logic [63:0]      ddr_rdata;
  logic [1:0]       grant;

  int n_vec  = 0;
  int n_miss = 0;

  ddr_port_arbiter #(.MAX_CONSEC(4)) dut (
    .clkddr          (clkddr),
    .reset           (reset),
    .m_acquire       (m_acquire),
    .m_read          (m_read),
    .m_write         (m_write),
    .m_addr          (m_addr),
    .m_burstcnt      (m_burstcnt),
    .m_wdata         (m_wdata),
    .m_byteenable    (m_byteenable),
    .m_busy          (m_busy),
    .m_rdata_ready   (m_rdata_ready),
    .m_rdata         (m_rdata),
    .ddr_read        (ddr_read),
    .ddr_write       (ddr_write),
    .ddr_addr        (ddr_addr),
    .ddr_burstcnt    (ddr_burstcnt),
    .ddr_wdata       (ddr_wdata),
    .ddr_byteenable  (ddr_byteenable),
    .ddr_busy        (ddr_busy),
    .ddr_rdata_ready (ddr_rdata_ready),
    .ddr_rdata       (ddr_rdata),
    .grant           (grant)
  );

  always #5 clkddr = ~clkddr;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // inputs change 2 time units after the edge, checks follow 1 unit later
  task automatic cyc();
    @(posedge clkddr);
    #2;
  endtask

  initial begin
    reset           = 1'b1;
    m_acquire       = '0;
    m_read          = '0;
    m_write         = '0;
    m_addr          = '0;
    m_burstcnt      = '0;
    m_wdata         = '0;
    m_byteenable    = '0;
    ddr_busy        = 1'b1;
    ddr_rdata_ready = 1'b0;
    ddr_rdata       = '0;
    repeat (3) cyc();
    #1;
    check_val("rst_grant", grant, 2'b00);
    check_val("rst_busy", m_busy, 2'b11);
    check_val("rst_rdy", m_rdata_ready, 2'b00);
    check_val("rst_rd", ddr_read, 1'b0);
    check_val("rst_wr", ddr_write, 1'b0);
    check_val("rst_outstd", dut.r_outstd, 0);
    check_val("rst_consec", dut.r_consec0, 0);
    reset = 1'b0;
    repeat (6) cyc();

    // single read, burst 4
    m_acquire[0] = 1'b1; m_read[0] = 1'b1; m_addr[0] = 29'h100; m_burstcnt[0] = 8'd4;
    #1;
    check_val("t1_idle_grant", grant, 2'b00);
    check_val("t1_idle_busy", m_busy, 2'b11);
    check_val("t1_idle_rd", ddr_read, 1'b0);
    cyc(); #1;
    check_val("t1_grant", grant, 2'b01);
    check_val("t1_rd", ddr_read, 1'b1);
    check_val("t1_addr", ddr_addr, 29'h100);
    check_val("t1_bc", ddr_burstcnt, 8'd4);
    check_val("t1_busy_held", m_busy, 2'b11);
    cyc(); ddr_busy = 1'b0; #1;
    check_val("t1_busy_acc", m_busy, 2'b10);
    check_val("t1_rd_acc", ddr_read, 1'b1);
    cyc(); m_read[0] = 1'b0; ddr_busy = 1'b1; ddr_rdata_ready = 1'b1; ddr_rdata = 64'hA0; #1;
    check_val("t1_outstd4", dut.r_outstd, 4);
    check_val("t1_rdy0", m_rdata_ready, 2'b01);
    check_val("t1_rdata", m_rdata, 64'hA0);
    for (int i = 1; i <= 3; i++) begin
      cyc(); ddr_rdata = 64'hA0 + 64'(i); #1;
      check_val("t1_rdy", m_rdata_ready, 2'b01);
      check_val("t1_outstd", dut.r_outstd, 64'(4 - i));
    end
    cyc(); ddr_rdata_ready = 1'b0; m_acquire[0] = 1'b0; #1;
    check_val("t1_outstd0", dut.r_outstd, 0);
    check_val("t1_grant_hold", grant, 2'b01);
    check_val("t1_rdy_idle", m_rdata_ready, 2'b00);
    cyc(); #1;
    check_val("t1_release", grant, 2'b00);
    check_val("t1_rel_busy", m_busy, 2'b11);

    // early acquire drop with 3 beats pending
    m_acquire[0] = 1'b1; m_read[0] = 1'b1; m_addr[0] = 29'h140; m_burstcnt[0] = 8'd5;
    cyc(); ddr_busy = 1'b0; #1;
    check_val("t2_grant", grant, 2'b01);
    check_val("t2_busy", m_busy, 2'b10);
    cyc(); m_read[0] = 1'b0; ddr_busy = 1'b1; ddr_rdata_ready = 1'b1; #1;
    check_val("t2_outstd5", dut.r_outstd, 5);
    check_val("t2_rdy", m_rdata_ready, 2'b01);
    cyc(); #1;
    check_val("t2_outstd4", dut.r_outstd, 4);
    cyc(); ddr_rdata_ready = 1'b0; m_acquire[0] = 1'b0; #1;
    check_val("t2_outstd3", dut.r_outstd, 3);
    check_val("t2_hold", grant, 2'b01);
    for (int i = 0; i < 3; i++) begin
      cyc(); ddr_rdata_ready = 1'b1; #1;
      check_val("t2_hold_beats", grant, 2'b01);
      check_val("t2_rdy_beats", m_rdata_ready, 2'b01);
      check_val("t2_outstd", dut.r_outstd, 64'(3 - i));
    end
    cyc(); #1;
    check_val("t2_release", grant, 2'b00);
    check_val("t2_stray_rdy", m_rdata_ready, 2'b00);
    check_val("t2_outstd_rel", dut.r_outstd, 0);
    cyc(); ddr_rdata_ready = 1'b0; #1;
    check_val("t2_no_underflow", dut.r_outstd, 0);

    // contention: both acquire in the same idle cycle
    m_acquire = 2'b11;
    m_write[0] = 1'b1; m_addr[0] = 29'h300; m_burstcnt[0] = 8'd1; m_wdata[0] = 64'h55;
    m_byteenable[0] = 8'h0F;
    m_read[1] = 1'b1; m_addr[1] = 29'h200; m_burstcnt[1] = 8'd2;
    cyc(); m_acquire[0] = 1'b0; ddr_busy = 1'b0; #1;
    check_val("t3_grant0", grant, 2'b01);
    check_val("t3_busy", m_busy, 2'b10);
    check_val("t3_wr", ddr_write, 1'b1);
    check_val("t3_rd_blocked", ddr_read, 1'b0);
    check_val("t3_addr0", ddr_addr, 29'h300);
    check_val("t3_consec1", dut.r_consec0, 1);
    cyc(); m_write[0] = 1'b0; ddr_busy = 1'b1; #1;
    check_val("t3_gap", grant, 2'b00);
    check_val("t3_gap_busy", m_busy, 2'b11);
    check_val("t3_gap_rd", ddr_read, 1'b0);
    cyc(); #1;
    check_val("t3_grant1", grant, 2'b10);
    check_val("t3_rd1", ddr_read, 1'b1);
    check_val("t3_addr1", ddr_addr, 29'h200);
    check_val("t3_bc1", ddr_burstcnt, 8'd2);
    check_val("t3_busy1_held", m_busy, 2'b11);
    check_val("t3_consec0", dut.r_consec0, 0);
    ddr_busy = 1'b0; #1;
    check_val("t3_busy1_acc", m_busy, 2'b01);
    cyc(); m_read[1] = 1'b0; ddr_busy = 1'b1; ddr_rdata_ready = 1'b1; #1;
    check_val("t3_rdy1", m_rdata_ready, 2'b10);
    check_val("t3_outstd2", dut.r_outstd, 2);
    cyc(); m_acquire[1] = 1'b0; #1;
    check_val("t3_rdy1b", m_rdata_ready, 2'b10);
    check_val("t3_outstd1", dut.r_outstd, 1);
    cyc(); ddr_rdata_ready = 1'b0; #1;
    check_val("t3_release", grant, 2'b00);
    check_val("t3_outstd0", dut.r_outstd, 0);

    // starvation bound: four display grants, then requester 1
    m_acquire = 2'b11; m_read[1] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc(); m_acquire[0] = 1'b0; #1;
      check_val("t4_own0", grant, 2'b01);
      check_val("t4_consec", dut.r_consec0, 64'(k));
      check_val("t4_rd_blocked", ddr_read, 1'b0);
      cyc(); m_acquire[0] = 1'b1; #1;
      check_val("t4_gap", grant, 2'b00);
    end
    cyc(); #1;
    check_val("t4_own1", grant, 2'b10);
    check_val("t4_consec_clr", dut.r_consec0, 0);
    check_val("t4_rd1", ddr_read, 1'b1);
    m_acquire = 2'b00; m_read[1] = 1'b0;
    cyc(); #1;
    check_val("t4_release", grant, 2'b00);

    // write pass-through on requester 1
    m_acquire[1] = 1'b1; m_write[1] = 1'b1; m_addr[1] = 29'h1234; m_burstcnt[1] = 8'd2;
    m_wdata[1] = 64'h1122334455667788; m_byteenable[1] = 8'hFF;
    cyc(); ddr_busy = 1'b0; #1;
    check_val("t5_grant", grant, 2'b10);
    check_val("t5_wr", ddr_write, 1'b1);
    check_val("t5_wdata", ddr_wdata, 64'h1122334455667788);
    check_val("t5_be", ddr_byteenable, 8'hFF);
    check_val("t5_bc", ddr_burstcnt, 8'd2);
    check_val("t5_addr", ddr_addr, 29'h1234);
    check_val("t5_busy", m_busy, 2'b01);
    cyc(); m_acquire[1] = 1'b0; #1;
    check_val("t5_outstd", dut.r_outstd, 0);
    check_val("t5_wr2", ddr_write, 1'b1);
    check_val("t5_grant2", grant, 2'b10);
    cyc(); m_write[1] = 1'b0; ddr_busy = 1'b1; #1;
    check_val("t5_release", grant, 2'b00);
    check_val("t5_wr_idle", ddr_write, 1'b0);
    check_val("t5_wdata_hold", ddr_wdata, 64'h1122334455667788);
    check_val("t5_outstd_idle", dut.r_outstd, 0);

    // reset in the middle of a burst
    m_acquire[0] = 1'b1; m_read[0] = 1'b1; m_addr[0] = 29'h500; m_burstcnt[0] = 8'd5;
    cyc(); ddr_busy = 1'b0;
    cyc(); m_read[0] = 1'b0; ddr_busy = 1'b1; #1;
    check_val("t6_outstd5", dut.r_outstd, 5);
    check_val("t6_grant", grant, 2'b01);
    reset = 1'b1;
    cyc(); reset = 1'b0; m_acquire[0] = 1'b0; #1;
    check_val("t6_rst_grant", grant, 2'b00);
    check_val("t6_rst_busy", m_busy, 2'b11);
    check_val("t6_rst_outstd", dut.r_outstd, 0);
    check_val("t6_rst_rd", ddr_read, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(); ddr_rdata_ready = 1'b1; #1;
      check_val("t6_drop_rdy", m_rdata_ready, 2'b00);
      check_val("t6_drop_outstd", dut.r_outstd, 0);
    end
    cyc(); ddr_rdata_ready = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ddr_port_arbiter.md
# ddr_port_arbiter

Two-requester arbiter sharing the single core DDR host port (64-bit data, 8-byte words, burst reads and writes) between the FMV frame player (requester 0, display, latency-critical) and the MPEG decoder's frame-store writer/reader (requester 1).
- The arbiter grants whole transactions, delimited by each requester's `acquire`.
- It muxes command signals from the current owner to DDR and returns `busy`/`rdata_ready` to that owner only.
- It never releases a grant while read beats are still outstanding.
- Requester 0 has fixed priority, with a starvation bound for requester 1.

## Interface
Parameters:
- `MAX_CONSEC`, default 4: consecutive requester-0 grants allowed while requester 1 is waiting before requester 1 must be served.

Ports (arrays indexed `[1:0]`, index 0 = display):
- `clkddr`  in  1  DDR clock, the only clock.
- `reset`  in  1  synchronous, active-high reset, sampled on `clkddr`.
- `m_acquire`  in  2  requester holds transaction ownership request.
- `m_read`, `m_write`  in  2 each  command strobes; held until `m_busy` low.
- `m_addr`  in  2x29  word address, already including core base.
- `m_burstcnt`  in  2x8  beats per command; values 1..255.
- `m_wdata`  in  2x64  write data.
- `m_byteenable`  in  2x8  byte enables.
- `m_busy`  out  2  1 = command not accepted this cycle.
- `m_rdata_ready`  out  2  read beat valid for that requester.
- `m_rdata`  out  64  read data, broadcast to both requesters.
- `ddr_read`, `ddr_write`  out  1 each  to DDR host.
- `ddr_addr`  out  29;  `ddr_burstcnt`  out  8;  `ddr_wdata`  out  64;  `ddr_byteenable`  out  8.
- `ddr_busy`  in  1;  `ddr_rdata_ready`  in  1;  `ddr_rdata`  in  64.
- `grant`  out  2  one-hot current owner (00 = none), for debug.

## Operation
State machine: IDLE, OWN0, OWN1.

IDLE:
- Pick an owner from `m_acquire` sampled this cycle.
- Requester 1 wins if `m_acquire[1]` and either `m_acquire[0]==0` or `consec0 >= MAX_CONSEC`.
- Otherwise requester 0 wins if `m_acquire[0]`.
- The transition is registered.

OWNx, signal routing:
- `ddr_read/ddr_write/addr/burstcnt/wdata/byteenable` are combinationally muxed from requester x.
- `m_busy[x] = ddr_busy`; `m_busy[other] = 1`.
- `m_rdata_ready[x] = ddr_rdata_ready`; `m_rdata_ready[other] = 0`.
- In IDLE: both `m_busy` = 1, `ddr_read = ddr_write = 0`, other `ddr_*` outputs hold the last mux value.

Outstanding counter `outstd` (9 bits):
- Per cycle: `+ m_burstcnt[x]` when `ddr_read && !ddr_busy`; `−1` when `ddr_rdata_ready`.
- Both may occur in the same cycle; net them.
- Write beats are not counted (write data is presented with the strobe).

Release and starvation counter:
- OWNx → IDLE when `m_acquire[x]==0 && outstd==0` (after the cycle's update), or when `outstd` would reach 0 in that cycle with acquire already low.
- No direct OWNx → OWNy hand-off: one IDLE cycle always separates grants.
- `consec0` (3+ bits, saturating): increments on each OWN0 entry while `m_acquire[1]` is high; clears on OWN1 entry or when `m_acquire[1]` is low in IDLE.

Error guards:
- `ddr_rdata_ready` while `outstd==0` is ignored; the counter does not underflow.
- A command strobe from the owner while `m_acquire[x]` is low is still forwarded; the release condition governs.

Reset:
- Takes effect in any state, including mid-burst: state → IDLE, `outstd` = 0, `consec0` = 0, `grant` = 00, both `m_busy` = 1, `m_rdata_ready` = 00, `ddr_read = ddr_write = 0`.
- Beats still returning from DDR after reset are dropped (not routed).

## Timing
- Grant latency: `m_acquire` high in cycle n (IDLE) → `grant` set in n+1; command visible on `ddr_*` in n+1, same cycle as the requester's held strobe.
- Command path from owner to DDR and busy/ready path back are combinational: zero added latency.
- Minimum transaction occupancy: 1 grant cycle + DDR time + 1 IDLE cycle.
- Release is evaluated on the registered state; `grant` drops in the cycle after the release condition is met.
- `m_rdata` is always `ddr_rdata`, unregistered.

## Test plan
- **Single read:** requester 0 raises acquire + read, burstcnt = 4, at cycle 10. Required: `grant` = 01 at 11; `ddr_read` 1 until `ddr_busy` low; 4 `m_rdata_ready[0]` pulses; `outstd` returns 0; `grant` = 00 one cycle after acquire drops.
- **Early acquire drop:** requester 0 drops acquire after the read is accepted but with 3 beats pending. Required: grant held until the last beat; `m_rdata_ready[1]` stays 0 throughout.
- **Contention:** both acquire in the same IDLE cycle. Required: requester 0 granted; requester 1 sees `m_busy[1]`=1 and its strobe stays held; requester 1 is granted after release plus one IDLE cycle.
- **Starvation bound:** `MAX_CONSEC` = 4; requester 0 re-acquires continuously while requester 1 waits. Required: 4 OWN0 grants, then OWN1, then `consec0` = 0.
- **Write pass-through:** requester 1 write, burstcnt = 2, wdata = 0x1122334455667788, byteenable = 0xFF. Required: these values appear on `ddr_*`; `outstd` stays 0; release as soon as acquire is low.
- **Reset mid-burst:** reset asserted with `outstd` = 5 in OWN0. Required: next cycle IDLE with `outstd` = 0 and `m_busy` = 11; later `ddr_rdata_ready` pulses produce no `m_rdata_ready`.
